// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port memory sequencer between the IF/MEM pipeline stages
// and a byte-wide synchronous RAM. Each 32-bit instruction fetch or
// 1/2/4-byte load/store is broken into consecutive byte transfers, and the
// assembled result is returned with a one-cycle done pulse.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   if_req/if_addr     instruction fetch request (always 4 bytes)
//   if_done/if_inst    fetch completion pulse and little-endian instruction
//   mem_req/mem_we     load (we=0) or store (we=1) request from MEM
//   mem_size           00 byte, 01 half, 10/11 word
//   mem_addr/wdata     load/store byte address and store data
//   mem_done/rdata     completion pulse and zero-extended load data
//   stallreq_from_*    combinational stall requests to the pipeline
//   ram_a/rw/dout/din  byte RAM interface; ram_din lags ram_a by one cycle
module mem_ctrl #(
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_done,
   output logic [31:0]       if_inst,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [1:0]        mem_size,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic              mem_done,
   output logic [31:0]       mem_rdata,
   output logic              stallreq_from_if,
   output logic              stallreq_from_mem,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_rw,
   output logic [7:0]        ram_dout,
   input  logic [7:0]        ram_din
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } state_t;

   localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t      state;
   state_t      next_state;
   logic [2:0]  cnt;
   logic [2:0]  nbytes;
   logic [2:0]  req_bytes;
   logic        port_mem;
   logic [31:0] wdata_q;
   logic [31:0] buf_q;
   logic [31:0] assembled;
   logic [31:0] wdata_shift;
   logic [1:0]  lane;
   logic        grant;

   // A request is only taken in IDLE; MEM always wins over IF so a load or
   // store never waits behind the next fetch.
   always_comb begin
      grant     = if_req | mem_req;
      req_bytes = 3'd4;
      if (mem_req) begin
         case (mem_size)
            2'b00:   req_bytes = 3'd1;
            2'b01:   req_bytes = 3'd2;
            default: req_bytes = 3'd4;
         endcase
      end
   end

   // Stall requests fall the same cycle the done pulse appears, so the
   // pipeline advances exactly when the data is presented.
   always_comb begin
      stallreq_from_if  = if_req & ~if_done;
      stallreq_from_mem = mem_req & ~mem_done;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and RAM-side outputs. A read stays one cycle longer than a
   // write (cnt runs 0..N) because the last byte only shows on ram_din the
   // cycle after its address was driven.
   always_comb begin
      next_state  = state;
      ram_rw      = 1'b0;
      ram_dout    = 8'h00;
      if_done     = 1'b0;
      mem_done    = 1'b0;
      wdata_shift = wdata_q >> {cnt[1:0], 3'b000};
      case (state)
         IDLE: begin
            if (grant) begin
               next_state = (mem_req && mem_we) ? WRITE : READ;
            end
         end
         READ: begin
            if (cnt == nbytes) begin
               next_state = DONE;
            end
         end
         WRITE: begin
            ram_rw   = 1'b1;
            ram_dout = wdata_shift[7:0];
            if (cnt == nbytes - 3'd1) begin
               next_state = DONE;
            end
         end
         DONE: begin
            if_done    = ~port_mem;
            mem_done   = port_mem;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // The byte arriving now belongs to the address driven last cycle, hence
   // lane cnt-1 rather than cnt.
   always_comb begin
      lane      = cnt[1:0] - 2'd1;
      assembled = buf_q;
      case (lane)
         2'd0: assembled[7:0]   = ram_din;
         2'd1: assembled[15:8]  = ram_din;
         2'd2: assembled[23:16] = ram_din;
         2'd3: assembled[31:24] = ram_din;
         default: assembled = buf_q;
      endcase
   end

   // Transfer datapath: latch the granted request, step the RAM address
   // through N bytes (wrapping naturally at the address width), and publish
   // the assembled word to the owning port only on the final byte so a
   // reset mid-transfer leaves no partial result behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= 3'd0;
         nbytes    <= 3'd0;
         port_mem  <= 1'b0;
         wdata_q   <= 32'h0;
         buf_q     <= 32'h0;
         ram_a     <= '0;
         if_inst   <= 32'h0;
         mem_rdata <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  cnt      <= 3'd0;
                  nbytes   <= req_bytes;
                  port_mem <= mem_req;
                  wdata_q  <= mem_req ? mem_wdata : 32'h0;
                  buf_q    <= 32'h0;
                  ram_a    <= mem_req ? mem_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
               end
            end
            READ: begin
               cnt <= cnt + 3'd1;
               if (cnt < nbytes - 3'd1) begin
                  ram_a <= ram_a + A_ONE;
               end
               if (cnt != 3'd0) begin
                  buf_q <= assembled;
                  if (cnt == nbytes) begin
                     if (port_mem) begin
                        mem_rdata <= assembled;
                     end else begin
                        if_inst <= assembled;
                     end
                  end
               end
            end
            WRITE: begin
               cnt <= cnt + 3'd1;
               if (cnt < nbytes - 3'd1) begin
                  ram_a <= ram_a + A_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port memory arbiter/sequencer between the IF and MEM stages and a byte-wide synchronous RAM.
- Serialises 32-bit instruction fetches and 1/2/4-byte loads and stores into byte transfers.
- Produces the stall requests consumed by the pipeline stall controller (stallreq_from_if, stallreq_from_mem) and returns assembled data with a one-cycle done pulse.

Parameters:
ADDR_W, 17, RAM address width; ram_a = low ADDR_W bits of the byte address.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high (`Enable)
if_req  input  1  IF requests a 4-byte instruction fetch
if_addr  input  32  fetch byte address
if_done  output  1  one-cycle pulse; if_inst valid
if_inst  output  32  fetched instruction, little-endian
mem_req  input  1  MEM requests a load or store
mem_we  input  1  1 = store, 0 = load
mem_size  input  2  00 byte, 01 half, 10/11 word
mem_addr  input  32  load/store byte address
mem_wdata  input  32  store data; low bytes used first
mem_done  output  1  one-cycle pulse; mem_rdata valid
mem_rdata  output  32  load data, zero-extended
stallreq_from_if  output  1  IF stall request
stallreq_from_mem  output  1  MEM stall request
ram_a  output  ADDR_W  RAM byte address
ram_rw  output  1  1 = write, 0 = read
ram_dout  output  8  RAM write byte
ram_din  input  8  RAM read byte; valid in the cycle after its address is driven

Behaviour:
- Reset, sampled at posedge: state IDLE; all outputs 0, including ram_rw = 0 and both done pulses; counters and data cleared.
- Reset mid-transfer:
  - Next cycle is IDLE with ram_rw = 0.
  - No done pulse; partial data discarded.
  - A request present in the first cycle after rst deasserts is granted in that cycle.
- FSM states: IDLE -> READ or WRITE -> DONE -> IDLE.
- Arbitration in IDLE: mem_req beats if_req. No preemption; a request arriving during another transfer waits.
- Cycle numbering: cycle 0 = the IDLE cycle in which the request is granted. At the end of cycle 0, latch address, size, we and wdata. N = 1, 2 or 4 bytes; IF is always N = 4.
- Address generation: cycles 1..N drive ram_a = (base + k - 1) truncated to ADDR_W. Addresses wrap at 2^ADDR_W. Unaligned addresses are legal.
- Read:
  - ram_rw = 0, ram_dout = 0.
  - Byte k-1 is captured from ram_din at the end of cycle k+1 into bits [8(k-1)+7 : 8(k-1)].
  - DONE in cycle N+2 with the matching done pulse. Word read: done in cycle 6.
- Write:
  - Cycles 1..N drive ram_rw = 1 and ram_dout = mem_wdata byte k-1.
  - DONE in cycle N+1. Word write: done in cycle 5.
- In DONE: ram_rw = 0, requests ignored; arbitration resumes the next cycle.
- Data hold: if_inst and mem_rdata hold their value until the next completing read of the same port. Unused upper bytes are 0. Stores do not modify mem_rdata.
- In IDLE and DONE, ram_a holds its last value.
- Stall outputs are combinational:
  - stallreq_from_if = if_req & ~if_done
  - stallreq_from_mem = mem_req & ~mem_done
- Requester contract: hold req and its inputs stable until done. A req dropped mid-transfer does not abort it; the transfer completes and done still pulses. Stores must never be torn.

Test Plan:
1. IF fetch at 0x1000, RAM bytes 13 05 00 00 -> ram_a 0x1000..0x1003 in cycles 1-4; if_done in cycle 6 with if_inst = 0x00000513; stallreq_from_if high in cycles 0-5, low in cycle 6.
2. Byte store: addr 0x200, wdata 0xDEADBEEF, size 00 -> cycle 1 has ram_rw = 1, ram_a = 0x200, ram_dout = 0xEF; mem_done and ram_rw = 0 in cycle 2.
3. if_req and mem_req both in cycle 0, MEM half load at 0x104 (bytes 34 12) -> mem_done in cycle 4, mem_rdata = 0x00001234; IF granted in cycle 5, if_done in cycle 11; stallreq_from_if high in cycles 0-10.
4. Half load at 0x1FFFF with ADDR_W = 17 -> ram_a 0x1FFFF then 0x00000; bytes assembled in that order.
5. rst high in cycle 3 of a word store -> ram_rw = 0 from cycle 4 and no mem_done. A new if_req with rst low in cycle 4 is granted there (cycle 0').
6. mem_size = 11 load -> 4 bytes, done in cycle 6. if_req dropped in cycle 2 of a fetch -> fetch completes, if_done pulses in cycle 6, stallreq_from_if low from cycle 2.
